// File: rtl/xbus_mem_target.sv
// On-chip byte memory behind the 6502 external SRAM bus, plus a byte-stream
// loader (W/R commands) that can preload or dump memory while the CPU is held.
module xbus_mem_target #(
    parameter int unsigned AW = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        sram_oe,
    input  logic [7:0]  sram_dout,
    output logic [7:0]  sram_din,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        rs_valid,
    output logic [7:0]  rs_data,
    input  logic        rs_ready,
    output logic        cpu_hold,
    output logic [7:0]  err_cnt
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {
        S_CMD, S_AHI, S_ALO, S_LEN, S_WDATA, S_RDATA
    } state_t;

    logic [7:0] mem [DEPTH];

    state_t          state, state_n;
    logic            op_wr, op_wr_n;
    logic [15:0]     ptr, ptr_n, ptr_inc;
    logic [8:0]      cnt, cnt_n;
    logic [7:0]      err_n;
    logic            pend, pend_n;
    logic [AW-1:0]   pend_addr, pend_addr_n;
    logic [7:0]      pend_data, pend_data_n;
    logic            rs_valid_n;
    logic [7:0]      rs_data_n;
    logic            ld_ready_n;
    logic            accept;
    logic            ld_wr;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [7:0]      mem_wd;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^addr[15:AW];

    // Zero-latency bus read; upper address bits alias.
    assign sram_din = mem[addr[AW-1:0]];
    assign accept   = ld_valid & ld_ready;
    assign ptr_inc  = ptr + 16'd1;

    always_comb begin
        state_n     = state;
        op_wr_n     = op_wr;
        ptr_n       = ptr;
        cnt_n       = cnt;
        err_n       = err_cnt;
        pend_n      = pend;
        pend_addr_n = pend_addr;
        pend_data_n = pend_data;
        rs_valid_n  = rs_valid;
        rs_data_n   = rs_data;
        ld_wr       = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = '0;
        mem_wd      = '0;

        case (state)
            S_CMD: begin
                if (accept) begin
                    if (ld_data == CMD_W) begin
                        op_wr_n = 1'b1;
                        state_n = S_AHI;
                    end else if (ld_data == CMD_R) begin
                        op_wr_n = 1'b0;
                        state_n = S_AHI;
                    end else if (err_cnt != 8'hFF) begin
                        err_n = err_cnt + 8'd1;
                    end
                end
            end
            S_AHI: begin
                if (accept) begin
                    ptr_n[15:8] = ld_data;
                    state_n     = S_ALO;
                end
            end
            S_ALO: begin
                if (accept) begin
                    ptr_n[7:0] = ld_data;
                    state_n    = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    cnt_n = (ld_data == 8'd0) ? 9'd256 : {1'b0, ld_data};
                    if (op_wr) begin
                        state_n = S_WDATA;
                    end else begin
                        state_n    = S_RDATA;
                        rs_valid_n = 1'b1;
                        rs_data_n  = mem[ptr[AW-1:0]];
                    end
                end
            end
            S_WDATA: begin
                if (accept) begin
                    // A bus write owns the port this cycle; park the loader byte.
                    if (sram_oe) begin
                        pend_n      = 1'b1;
                        pend_addr_n = ptr[AW-1:0];
                        pend_data_n = ld_data;
                    end else begin
                        ld_wr = 1'b1;
                    end
                    ptr_n = ptr_inc;
                    cnt_n = cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        state_n = S_CMD;
                    end
                end
            end
            S_RDATA: begin
                // rs_data only reloads on a handshake so it stays stable under backpressure.
                if (rs_valid && rs_ready) begin
                    ptr_n = ptr_inc;
                    cnt_n = cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        state_n    = S_CMD;
                        rs_valid_n = 1'b0;
                    end else begin
                        rs_data_n = mem[ptr_inc[AW-1:0]];
                    end
                end
            end
            default: begin
                state_n = S_CMD;
            end
        endcase

        // Single write port: bus first, then a parked loader byte, then a direct loader byte.
        if (sram_oe) begin
            mem_we = 1'b1;
            mem_wa = addr[AW-1:0];
            mem_wd = sram_dout;
        end else if (pend) begin
            mem_we = 1'b1;
            mem_wa = pend_addr;
            mem_wd = pend_data;
            pend_n = 1'b0;
        end else if (ld_wr) begin
            mem_we = 1'b1;
            mem_wa = ptr[AW-1:0];
            mem_wd = ld_data;
        end

        ld_ready_n = !pend_n && (state_n != S_RDATA);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_CMD;
            op_wr     <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            err_cnt   <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            rs_valid  <= 1'b0;
            rs_data   <= '0;
            ld_ready  <= 1'b1;
            cpu_hold  <= 1'b0;
        end else begin
            state     <= state_n;
            op_wr     <= op_wr_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            err_cnt   <= err_n;
            pend      <= pend_n;
            pend_addr <= pend_addr_n;
            pend_data <= pend_data_n;
            rs_valid  <= rs_valid_n;
            rs_data   <= rs_data_n;
            ld_ready  <= ld_ready_n;
            cpu_hold  <= (state != S_CMD);
        end
    end

endmodule

// File: tb/tb_xbus_mem_target.sv
// Directed bench for xbus_mem_target: bus access, loader W/R commands,
// write collision, length-0/pointer wrap, error counter and mid-read reset.
module tb_xbus_mem_target;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        sram_oe;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        rs_valid;
    logic [7:0]  rs_data;
    logic        rs_ready;
    logic        cpu_hold;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    xbus_mem_target #(.AW(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .sram_oe   (sram_oe),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rs_valid  (rs_valid),
        .rs_data   (rs_data),
        .rs_ready  (rs_ready),
        .cpu_hold  (cpu_hold),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_data  = b;
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) begin
            check("ld_ready_timeout", 16'(ld_ready), 16'd1);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        addr      = a;
        sram_oe   = 1'b1;
        sram_dout = d;
        @(negedge clk);
        sram_oe   = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, 16'(sram_din), 16'(exp));
    endtask

    initial begin
        logic [7:0] exp_rd [2];
        exp_rd = '{8'h11, 8'h22};

        reset = 1'b0; addr = '0; sram_oe = 1'b0; sram_dout = '0;
        ld_valid = 1'b0; ld_data = '0; rs_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ld_ready", 16'(ld_ready), 16'd1);
        check("rst_rs_valid", 16'(rs_valid), 16'd0);
        check("rst_rs_data",  16'(rs_data),  16'd0);
        check("rst_cpu_hold", 16'(cpu_hold), 16'd0);
        check("rst_err_cnt",  16'(err_cnt),  16'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: bus write then same-cycle read, plus upper-address aliasing
        bus_wr(16'h0123, 8'hA5);
        bus_rd("bus_rd_0123", 16'h0123, 8'hA5);
        bus_rd("bus_rd_alias", 16'hF123, 8'hA5);

        // 2: loader write of three bytes
        send_byte(8'h57);
        send_byte(8'h01);
        check("w_hold_byte2", 16'(cpu_hold), 16'd1);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("w_hold_after_cc", 16'(cpu_hold), 16'd1);
        @(negedge clk);
        check("w_hold_drop", 16'(cpu_hold), 16'd0);
        bus_rd("w_mem_100", 16'h0100, 8'hAA);
        bus_rd("w_mem_101", 16'h0101, 8'hBB);
        bus_rd("w_mem_102", 16'h0102, 8'hCC);

        // 3: loader read with backpressure
        send4(8'h57, 8'h02, 8'h00, 8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send4(8'h52, 8'h02, 8'h00, 8'h02);
        check("r_valid", 16'(rs_valid), 16'd1);
        check("r_ld_ready_low", 16'(ld_ready), 16'd0);
        repeat (4) @(negedge clk);
        bus_wr(16'h0200, 8'h99);
        check("r_hold_data", 16'(rs_data), 16'h11);
        check("r_hold_valid", 16'(rs_valid), 16'd1);
        rs_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("r_valid_k", 16'(rs_valid), 16'd1);
            check("r_data_k", 16'(rs_data), 16'(exp_rd[k]));
            @(negedge clk);
        end
        rs_ready = 1'b0;
        check("r_done_valid", 16'(rs_valid), 16'd0);
        check("r_done_ld_ready", 16'(ld_ready), 16'd1);
        bus_rd("r_bus_wr_landed", 16'h0200, 8'h99);

        // 4: loader write colliding with bus writes to the same address
        send4(8'h57, 8'h03, 8'h00, 8'h01);
        addr = 16'h0300; sram_oe = 1'b1; sram_dout = 8'h77;
        ld_valid = 1'b1; ld_data = 8'h5A;
        @(negedge clk);
        ld_valid = 1'b0;
        check("col_ld_ready_c2", 16'(ld_ready), 16'd0);
        @(negedge clk);
        check("col_ld_ready_c3", 16'(ld_ready), 16'd0);
        #1;
        check("col_bus_val", 16'(sram_din), 16'h77);
        @(negedge clk);
        sram_oe = 1'b0;
        @(negedge clk);
        check("col_ld_ready_free", 16'(ld_ready), 16'd1);
        bus_rd("col_final", 16'h0300, 8'h5A);

        // 5: LEN=0 means 256 bytes, pointer wraps 0xFFFF -> 0x0000
        send4(8'h57, 8'hFF, 8'hFF, 8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
        end
        @(negedge clk);
        check("wrap_hold_drop", 16'(cpu_hold), 16'd0);
        bus_rd("wrap_0fff", 16'h0FFF, 8'h00);
        bus_rd("wrap_0000", 16'h0000, 8'h01);
        bus_rd("wrap_00fe", 16'h00FE, 8'hFF);
        bus_rd("wrap_0100_intact", 16'h0100, 8'hAA);

        check("err_zero", 16'(err_cnt), 16'd0);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h00);
        end
        check("err_ten", 16'(err_cnt), 16'd10);
        for (int i = 0; i < 290; i++) begin
            send_byte(8'h00);
        end
        check("err_sat", 16'(err_cnt), 16'hFF);

        // 6: reset in the middle of a read
        send4(8'h52, 8'h01, 8'h00, 8'h02);
        check("mid_valid", 16'(rs_valid), 16'd1);
        check("mid_data", 16'(rs_data), 16'hAA);
        check("mid_hold", 16'(cpu_hold), 16'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 16'(rs_valid), 16'd0);
        check("mid_rst_hold", 16'(cpu_hold), 16'd0);
        check("mid_rst_ld_ready", 16'(ld_ready), 16'd1);
        check("mid_rst_err", 16'(err_cnt), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_rd("mid_mem_101", 16'h0101, 8'hBB);
        bus_rd("mid_mem_102", 16'h0102, 8'hCC);
        send_byte(8'h41);
        check("mid_cmd_state", 16'(err_cnt), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
